// File: rtl/bsg_channel_remap_seq.sv
// Runtime-programmable channel permutation between the IO channels and the guts,
// with drain-before-remap and staggered per-channel enable bring-up.
module bsg_channel_remap_seq #(
  parameter int channels_p = 4,
  parameter int width_p = 8,
  parameter int settle_cycles_p = 16,
  parameter logic [channels_p-1:0] enabled_at_start_vec_p = '1,
  localparam int lg_c = $clog2(channels_p)
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          cfg_v_i,
  output logic                          cfg_ready_o,
  input  logic [channels_p*lg_c-1:0]    cfg_map_i,
  input  logic [channels_p-1:0]         cfg_en_i,
  input  logic [channels_p-1:0]         in_v_i,
  input  logic [channels_p*width_p-1:0] in_data_i,
  output logic [channels_p-1:0]         out_v_o,
  output logic [channels_p*width_p-1:0] out_data_o,
  output logic [channels_p-1:0]         chan_en_o,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int cnt_w = $clog2(settle_cycles_p+1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StDrain   = 2'd1;
  localparam logic [1:0] StBringup = 2'd2;

  function automatic logic [channels_p*lg_c-1:0] identity_map();
    logic [channels_p*lg_c-1:0] m;
    m = '0;
    for (int k = 0; k < channels_p; k++) m[k*lg_c +: lg_c] = lg_c'(k);
    return m;
  endfunction

  logic [1:0]                   state_q, state_d;
  logic [cnt_w-1:0]             cnt_q, cnt_d;
  logic [channels_p*lg_c-1:0]   map_q, map_d, pend_map_q, pend_map_d;
  logic [channels_p-1:0]        target_q, target_d, pend_en_q, pend_en_d;
  logic [channels_p-1:0]        en_q, en_d;
  logic                         err_q, err_d;
  logic                         ready_q;
  logic [channels_p-1:0]        out_v_q, out_v_d;
  logic [channels_p*width_p-1:0] out_data_q, out_data_d;

  logic [channels_p-1:0] seen;
  logic [channels_p-1:0] pending;
  logic [channels_p-1:0] next_bit;
  logic                  map_ok;
  logic                  cnt_last;

  // channels_p fields covering all channels_p values can only be a permutation
  always_comb begin
    seen = '0;
    for (int k = 0; k < channels_p; k++) begin
      for (int j = 0; j < channels_p; j++) begin
        if (cfg_map_i[k*lg_c +: lg_c] == lg_c'(j)) seen[j] = 1'b1;
      end
    end
    map_ok = &seen;
  end

  assign pending  = target_q & ~en_q;
  assign next_bit = pending & (~pending + channels_p'(1));
  assign cnt_last = (cnt_q == cnt_w'(settle_cycles_p - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    map_d      = map_q;
    target_d   = target_q;
    pend_map_d = pend_map_q;
    pend_en_d  = pend_en_q;
    en_d       = en_q;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (cfg_v_i) begin
          if (map_ok) begin
            err_d      = 1'b0;
            pend_map_d = cfg_map_i;
            pend_en_d  = cfg_en_i;
            en_d       = '0;
            cnt_d      = '0;
            state_d    = StDrain;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StDrain: begin
        if (cnt_last) begin
          map_d    = pend_map_q;
          target_d = pend_en_q;
          cnt_d    = '0;
          state_d  = StBringup;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      StBringup: begin
        if (pending == '0) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_last) begin
          en_d  = en_q | next_bit;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Output k takes the input its map field selects, gated by its own enable
  always_comb begin
    out_v_d    = '0;
    out_data_d = '0;
    for (int k = 0; k < channels_p; k++) begin
      for (int j = 0; j < channels_p; j++) begin
        if ((map_q[k*lg_c +: lg_c] == lg_c'(j)) && in_v_i[j] && en_q[k]) begin
          out_v_d[k]                       = 1'b1;
          out_data_d[k*width_p +: width_p] = in_data_i[j*width_p +: width_p];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q    <= StBringup;
      cnt_q      <= '0;
      map_q      <= identity_map();
      target_q   <= enabled_at_start_vec_p;
      pend_map_q <= identity_map();
      pend_en_q  <= '0;
      en_q       <= '0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      out_v_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      map_q      <= map_d;
      target_q   <= target_d;
      pend_map_q <= pend_map_d;
      pend_en_q  <= pend_en_d;
      en_q       <= en_d;
      err_q      <= err_d;
      ready_q    <= (state_d == StIdle);
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign chan_en_o   = en_q;
  assign err_o       = err_q;
  assign out_v_o     = out_v_q;
  assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_bsg_channel_remap_seq.sv
// Bench for bsg_channel_remap_seq: directed scenarios plus random traffic,
// all outputs compared every cycle against a time-based behavioural model.
module tb_bsg_channel_remap_seq;

  localparam int CH = 4;
  localparam int W = 8;
  localparam int SETTLE = 16;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic cfgV = 1'b0;
  logic [7:0] cfgMap = 8'h00;
  logic [3:0] cfgEn = 4'h0;
  logic [3:0] inV = 4'h0;
  logic [31:0] inData = 32'h0;
  logic cfgReady, busy, err;
  logic [3:0] outV, chanEn;
  logic [31:0] outData;

  always #5 clk = ~clk;

  bsg_channel_remap_seq #(
    .channels_p(CH), .width_p(W), .settle_cycles_p(SETTLE), .enabled_at_start_vec_p(4'hF)
  ) dut (
    .clk_i(clk), .reset_n_i(resetN), .cfg_v_i(cfgV), .cfg_ready_o(cfgReady),
    .cfg_map_i(cfgMap), .cfg_en_i(cfgEn), .in_v_i(inV), .in_data_i(inData),
    .out_v_o(outV), .out_data_o(outData), .chan_en_o(chanEn), .busy_o(busy), .err_o(err)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = bring-up/idle timeline from mStart, mode 1 = drain from mStart
  int mCyc = 0, mKind = 0, mStart = 0;
  int mMap[4], pendMap[4], prevMap[4];
  logic [3:0] mTarget = 4'hF, pendEn = 4'h0, expEn = 4'h0, prevEn;
  logic mErr = 1'b0, expReady = 1'b0, prevReady, modelLive = 1'b0;
  logic [3:0] expOutV = 4'h0;
  logic [31:0] expOutData = 32'h0;
  logic [3:0] sInV, sCfgEn;
  logic [31:0] sInData;
  logic [7:0] sCfgMap;
  logic sCfgV, sReset;

  function automatic bit isPerm(input logic [7:0] m);
    int hits[4];
    hits = '{default: 0};
    for (int k = 0; k < 4; k++) hits[m[k*2 +: 2]]++;
    for (int v = 0; v < 4; v++) if (hits[v] != 1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic computeControl();
    int e, n, k, taken;
    if (mKind == 1) begin
      expEn = 4'h0;
      expReady = 1'b0;
    end else begin
      e = mCyc - mStart;
      n = $countones(mTarget);
      k = e / SETTLE;
      if (k > n) k = n;
      expEn = 4'h0;
      taken = 0;
      for (int b = 0; b < 4; b++) begin
        if (mTarget[b] && taken < k) begin
          expEn[b] = 1'b1;
          taken++;
        end
      end
      expReady = (e >= n * SETTLE + 1);
    end
  endtask

  always @(posedge clk) begin
    sInV = inV; sInData = inData; sCfgV = cfgV; sCfgMap = cfgMap; sCfgEn = cfgEn; sReset = resetN;
    #1;
    mCyc++;
    prevEn = expEn;
    prevMap = mMap;
    prevReady = expReady;
    if (!sReset) begin
      modelLive = 1'b1;
      mKind = 0;
      mStart = mCyc;
      mTarget = 4'hF;
      for (int k = 0; k < 4; k++) mMap[k] = k;
      mErr = 1'b0;
      expOutV = 4'h0;
      expOutData = 32'h0;
    end else if (modelLive) begin
      for (int k = 0; k < 4; k++) begin
        expOutV[k] = sInV[prevMap[k]] & prevEn[k];
        expOutData[k*8 +: 8] = expOutV[k] ? sInData[prevMap[k]*8 +: 8] : 8'h00;
      end
      if (prevReady && sCfgV) begin
        if (isPerm(sCfgMap)) begin
          mKind = 1;
          mStart = mCyc;
          for (int k = 0; k < 4; k++) pendMap[k] = int'(sCfgMap[k*2 +: 2]);
          pendEn = sCfgEn;
          mErr = 1'b0;
        end else begin
          mErr = 1'b1;
        end
      end else if (mKind == 1 && mCyc - mStart == SETTLE) begin
        mKind = 0;
        mStart = mCyc;
        mMap = pendMap;
        mTarget = pendEn;
      end
    end
    computeControl();
    if (modelLive) begin
      checkOutput("outV", 32'(outV), 32'(expOutV));
      checkOutput("outData", outData, expOutData);
      checkOutput("chanEn", 32'(chanEn), 32'(expEn));
      checkOutput("cfgReady", 32'(cfgReady), 32'(expReady));
      checkOutput("busy", 32'(busy), 32'(!expReady));
      checkOutput("err", 32'(err), 32'(mErr));
    end
  end

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d);
    inV = v;
    inData = d;
  endtask

  task automatic acceptConfig(input logic [7:0] m, input logic [3:0] e);
    cfgMap = m;
    cfgEn = e;
    cfgV = 1'b1;
    @(negedge clk);
    cfgV = 1'b0;
  endtask

  task automatic waitReady(input int limit);
    for (int i = 0; i < limit && cfgReady !== 1'b1; i++) @(negedge clk);
    checkOutput("readyReached", 32'(cfgReady), 32'h1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "ChanEn"}, 32'(chanEn), 32'h0);
    checkOutput({tag, "Busy"}, 32'(busy), 32'h1);
    checkOutput({tag, "Ready"}, 32'(cfgReady), 32'h0);
    checkOutput({tag, "OutV"}, 32'(outV), 32'h0);
    checkOutput({tag, "Err"}, 32'(err), 32'h0);
  endtask

  task automatic checkBringup(input string tag);
    repeat (16) @(negedge clk);
    checkOutput({tag, "En16"}, 32'(chanEn), 32'h1);
    checkOutput("modelEn16", 32'(expEn), 32'h1);
    repeat (16) @(negedge clk);
    checkOutput({tag, "En32"}, 32'(chanEn), 32'h3);
    repeat (16) @(negedge clk);
    checkOutput({tag, "En48"}, 32'(chanEn), 32'h7);
    repeat (16) @(negedge clk);
    checkOutput({tag, "En64"}, 32'(chanEn), 32'hF);
    checkOutput({tag, "Ready64"}, 32'(cfgReady), 32'h0);
    checkOutput("modelEn64", 32'(expEn), 32'hF);
    @(negedge clk);
    checkOutput({tag, "Ready65"}, 32'(cfgReady), 32'h1);
    applyStimulus(4'b0100, 32'h00A5_0000);
    @(negedge clk);
    checkOutput({tag, "IdentV"}, 32'(outV), 32'h4);
    checkOutput({tag, "IdentData"}, outData, 32'h00A5_0000);
    applyStimulus(4'h0, 32'h0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    checkResetState("rst");
    checkBringup("boot");

    // Map {0,2,1,3}
    acceptConfig(8'hD8, 4'hF);
    checkOutput("drainEn", 32'(chanEn), 32'h0);
    checkOutput("drainBusy", 32'(busy), 32'h1);
    waitReady(200);
    applyStimulus(4'b0100, 32'h003C_0000);
    @(negedge clk);
    checkOutput("swzV", 32'(outV), 32'h2);
    checkOutput("swzData", outData, 32'h0000_3C00);
    applyStimulus(4'h0, 32'h0);

    // Map {0,0,1,3} is not a permutation
    acceptConfig(8'hD0, 4'hF);
    checkOutput("badErr", 32'(err), 32'h1);
    checkOutput("badReady", 32'(cfgReady), 32'h1);
    applyStimulus(4'b0100, 32'h003C_0000);
    @(negedge clk);
    checkOutput("keptV", 32'(outV), 32'h2);
    applyStimulus(4'h0, 32'h0);
    acceptConfig(8'hE4, 4'hF);
    checkOutput("errCleared", 32'(err), 32'h0);
    waitReady(200);

    // cfg_v held high through a whole reconfiguration
    cfgMap = 8'hE4;
    cfgEn = 4'hF;
    cfgV = 1'b1;
    @(negedge clk);
    checkOutput("holdBusy", 32'(busy), 32'h1);
    repeat (80) @(negedge clk);
    checkOutput("holdEn64", 32'(chanEn), 32'hF);
    checkOutput("holdReady64", 32'(cfgReady), 32'h0);
    @(negedge clk);
    checkOutput("holdReady65", 32'(cfgReady), 32'h1);
    cfgV = 1'b0;

    acceptConfig(8'hB1, 4'h0);
    waitReady(50);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'hF, $urandom);
      @(negedge clk);
      checkOutput("zeroEnV", 32'(outV), 32'h0);
      checkOutput("zeroEnChan", 32'(chanEn), 32'h0);
    end
    applyStimulus(4'h0, 32'h0);

    // Reset in the middle of a drain
    acceptConfig(8'h1B, 4'hF);
    repeat (5) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    checkResetState("midRst");
    checkBringup("midRst");

    for (int i = 0; i < 3000; i++) begin
      resetN = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      applyStimulus(4'($urandom), $urandom);
      cfgV = ($urandom_range(0, 19) == 0);
      if (cfgV) begin
        if ($urandom_range(0, 3) != 0) begin
          int p[4];
          int j, t;
          p = '{0, 1, 2, 3};
          for (int s = 3; s > 0; s--) begin
            j = $urandom_range(0, s);
            t = p[s]; p[s] = p[j]; p[j] = t;
          end
          for (int k = 0; k < 4; k++) cfgMap[k*2 +: 2] = 2'(p[k]);
        end else begin
          cfgMap = 8'($urandom);
        end
        cfgEn = 4'($urandom);
      end
      @(negedge clk);
    end
    cfgV = 1'b0;
    resetN = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/bsg_channel_remap_seq.md
# bsg_channel_remap_seq

Parametrised successor to the fixed B/C swizzle between the chip's source-synchronous IO channels and the guts. Routes `channels_p` input channels to `channels_p` output channels through a runtime-programmable permutation, with no fixed wiring. Also sequences per-channel enables, bringing channels up one at a time with a settle interval, and drains all channels before any remap. Sits between the IO pad wrappers and `bsg_guts`, in the core clock domain.

## Interface
- `channels_p`, 4: number of channels; must be ≥ 2.
- `width_p`, 8: data bits per channel.
- `settle_cycles_p`, 16: cycles between successive channel enables, and drain length; must be ≥ 1.
- `enabled_at_start_vec_p`, all ones (`channels_p` bits): channels brought up after reset.
- `lg_c` (local) = `$clog2(channels_p)`.

Ports:
- `clk_i`  in  1  core clock.
- `reset_n_i`  in  1  synchronous, active-low reset.
- `cfg_v_i`  in  1  new configuration valid.
- `cfg_ready_o`  out  1  configuration can be accepted (IDLE only).
- `cfg_map_i`  in  `channels_p*lg_c`  field k = input index feeding output k.
- `cfg_en_i`  in  `channels_p`  target enable vector for outputs.
- `in_v_i`  in  `channels_p`  per-input valid.
- `in_data_i`  in  `channels_p*width_p`  per-input data, channel k at `[k*width_p +: width_p]`.
- `out_v_o`  out  `channels_p`  per-output valid.
- `out_data_o`  out  `channels_p*width_p`  per-output data.
- `chan_en_o`  out  `channels_p`  current per-output enable.
- `busy_o`  out  1  FSM not in IDLE.
- `err_o`  out  1  sticky flag: last offered configuration was not a permutation.

## Operation
- A configuration is accepted when `cfg_v_i & cfg_ready_o`. `cfg_v_i` is ignored while busy.
- The map is valid iff every field is < `channels_p` and all fields are distinct.
  - Invalid map: `err_o` is set next cycle, the configuration is discarded, and the FSM stays IDLE.
  - Any accepted valid configuration clears `err_o`.
- FSM states:
  - IDLE: `cfg_ready_o`=1.
  - DRAIN: entered on a valid accept. `chan_en_o` goes to 0 on the next edge. A counter runs `settle_cycles_p` cycles. On the last DRAIN cycle the map register loads `cfg_map_i` (captured at accept), the target register loads `cfg_en_i`, and the FSM goes to BRINGUP.
  - BRINGUP:
    - The counter starts at 0 and increments each cycle.
    - When the counter reaches `settle_cycles_p-1` and pending (= target & ~`chan_en_o`) is nonzero, the lowest-index pending bit of `chan_en_o` is set and the counter is cleared.
    - In any BRINGUP cycle where pending is zero, the next state is IDLE.
- Datapath, registered, per output k:
  - `out_v_o[k]` ← `in_v_i[map[k]] & chan_en_o[k]`.
  - `out_data_o[k]` ← `in_data_i[map[k]]` when that valid term is 1, otherwise 0.
- The counter is `$clog2(settle_cycles_p+1)` bits wide and never wraps. It is cleared on every state entry.

## Timing
- Reset (`reset_n_i`=0 at an edge):
  - map = identity, target = `enabled_at_start_vec_p`.
  - `chan_en_o`=0, `out_v_o`=0, `out_data_o`=0, `err_o`=0, counter=0.
  - State = BRINGUP, so `busy_o`=1 and `cfg_ready_o`=0.
- Reset mid-DRAIN or mid-BRINGUP abandons the operation and restores the reset state in the next cycle. The pending configuration is lost.
- Datapath latency is 1 cycle from `in_*` to `out_*`, with no bubbles.
- A channel whose enable drops stops producing valids from the cycle after `chan_en_o` falls.
- Bring-up of N target channels (cycle 0 = first BRINGUP cycle):
  - Channel i (i-th lowest pending) is enabled, visible at cycle `i*settle_cycles_p`, i = 1..N.
  - IDLE is reached at cycle `N*settle_cycles_p + 1`.
  - With an all-zero target, IDLE is reached at cycle 1.
- Reconfiguration: accept at cycle a, DRAIN occupies cycles a+1 .. a+`settle_cycles_p`, BRINGUP starts at a+`settle_cycles_p`+1.
- `cfg_ready_o` = (state==IDLE) and is a registered output. `busy_o` = ~`cfg_ready_o`.

## Test plan
- Reset release, defaults (4 ch, settle 16, target 1111):
  - `chan_en_o` = 0001 at cycle 16, 0011 at 32, 0111 at 48, 1111 at 64.
  - `cfg_ready_o`=1 at cycle 65.
  - Identity routing: `in_data` channel 2 = 0xA5 appears on `out_data` channel 2 one cycle later.
- Remap to map {0,2,1,3} (the old 3120 swizzle), en 1111:
  - `chan_en_o`=0 one cycle after accept.
  - After bring-up, `in_v_i`=0100 with data 0x3C produces `out_v_o`=0010, `out_data` channel 1 = 0x3C.
- Invalid map {0,0,1,3}: `err_o`=1 the next cycle, state stays IDLE, routing unchanged. A subsequent valid accept clears `err_o`.
- `cfg_v_i` held high during BRINGUP: not accepted, and no DRAIN occurs until IDLE. Map with en 0000: `chan_en_o` stays 0 and `out_v_o` stays 0 regardless of `in_v_i`.
- `reset_n_i` low for 1 cycle mid-DRAIN: the next cycle shows the reset state (identity map, `chan_en_o`=0, `busy_o`=1), followed by a full bring-up to 1111 at cycle 64.
